intersection_phase_scheduler: RTL
=================================

Name: intersection_phase_scheduler

Overview:
Round-robin scheduler that shares one intersection among N_APPR approaches. Only one approach holds green at a time. Each approach raises a has-car request, and the block sequences each green through yellow and all-red clearance, with min-green, gap-out and max-out timing. Per-approach light buses drive the signal heads directly; owner and phase are exported for monitoring.

Parameters:
N_APPR, 4, number of approaches sharing the intersection (2..8)
MIN_GREEN, 35, minimum green length in cycles (>=1)
MAX_GREEN, 60, green length at which a waiting request forces max-out (>=MIN_GREEN)
YELLOW_T, 15, yellow length in cycles (>=1)
ALL_RED_T, 2, all-red clearance length in cycles (>=1)
CNT_W, 7, phase counter width; must hold MAX_GREEN-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
has_car  in  N_APPR  per-approach car-present level
light  out  3*N_APPR  per approach i, bits [3i+2:3i] = {green, yellow, red}, always one-hot
owner  out  clog2(N_APPR)  index of the approach holding or last holding right-of-way
phase  out  2  0=GREEN, 1=YELLOW, 2=ALL_RED, 3=WALK (WALK used only with option)

Behaviour:
- Reset (async, rst_n=0): phase=GREEN, owner=0, count=0, pending=0.
  - light: approach 0 = 100; all others = 001.
  - Outputs take these values immediately, including on reset mid-phase.
- All state is registered on posedge clk. Outputs decode combinationally from registers; zero latency from state.
- Light decode:
  - Owner in GREEN -> 100; owner in YELLOW -> 010.
  - Every other approach, in every phase -> 001.
- pending[i] (request latch):
  - Set when has_car[i]=1.
  - Exception: not set for the owner while phase=GREEN.
  - Cleared for the new owner on the cycle GREEN is entered. Clear wins over a simultaneous set.
- other_req = OR of pending[j] and has_car[j] over all j != owner.
- count: increments by 1 each cycle within a phase. Resets to 0 on every phase change. Held (saturates) at MAX_GREEN-1 in GREEN.
- GREEN -> YELLOW when all of the following hold:
  - count >= MIN_GREEN-1;
  - other_req=1;
  - has_car[owner]=0 (gap-out) OR count == MAX_GREEN-1 (max-out).
- If other_req=0, GREEN holds indefinitely, whatever the count.
- YELLOW -> ALL_RED when count == YELLOW_T-1. YELLOW therefore lasts exactly YELLOW_T cycles.
- ALL_RED -> GREEN when count == ALL_RED_T-1:
  - New owner = first approach with pending=1 (or has_car=1), searching from owner+1 upward modulo N_APPR, owner itself last.
  - If no request is present, owner is unchanged.
- Green lasts at least MIN_GREEN cycles and at most MAX_GREEN cycles while a request waits, except when a requester drops out.
- A request arriving during YELLOW or ALL_RED is eligible at that phase's ALL_RED exit.

Optional Feature:
PED_WALK_EN
- Adds input ped_req (1 bit), output walk (1 bit) and parameter WALK_T (default 20).
- ped_pend is set by ped_req and cleared on WALK entry.
- At ALL_RED exit with ped_pend=1: go to WALK instead of GREEN.
  - In WALK: all lights 001, walk=1, owner held.
  - After WALK_T cycles: return to ALL_RED for ALL_RED_T cycles, then perform normal owner selection.
- ped_pend counts as other_req during GREEN.
- Without the macro: no ped ports, walk is absent, and phase 3 is unreachable.

Decomposition:
- Package intersection_pkg holds:
  - phase enum (PH_GREEN, PH_YELLOW, PH_ALL_RED, PH_WALK);
  - light constants LIGHT_GREEN=3'b100, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b001.
- Sub-module rr_next_picker: combinational round-robin search. Inputs: request vector and current owner. Outputs: next index and a found flag.

Test Plan:
- Reset, has_car=0 for 100 cycles -> light=001_001_001_100, owner=0, phase=GREEN throughout.
- has_car[2] pulsed 1 cycle at cycle 5, has_car[0]=0 -> yellow at cycle 35 for 15 cycles, all-red 2 cycles, green on approach 2 at cycle 52, pending[2] cleared.
- has_car[0]=1 held, has_car[1]=1 from cycle 0 -> approach 0 max-outs: yellow at cycle 60, owner=1 green at cycle 77.
- has_car[1] and has_car[3] both set while owner=0 -> owner=1 next, then owner=3; approach 2 is skipped.
- rst_n low at cycle 40 during approach 0 yellow -> immediate 100 on approach 0, phase=GREEN, count=0, pendings cleared.
- With PED_WALK_EN: ped_req at cycle 3, has_car[1]=1 -> after yellow and all-red, WALK (walk=1, all red) for 20 cycles, all-red for 2, then green on approach 1.

Source files
------------

// File: rtl/intersection_pkg.sv
// intersection_pkg
//   Shared types and constants for the intersection phase scheduler.
//   - phase_t : signal phase encoding, also exported on the top-level phase port
//               (PH_WALK is reachable only when PED_WALK_EN is defined)
//   - LIGHT_* : per-approach signal head codes {green, yellow, red}
package intersection_pkg;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2,
    PH_WALK    = 2'd3
  } phase_t;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

endpackage

// File: rtl/rr_next_picker.sv
// rr_next_picker
//   Combinational round-robin search. Starting at cur+1 and wrapping modulo
//   N_APPR, returns the first index whose request bit is set; cur itself is
//   examined last.
//   Ports:
//     req      in  N_APPR  request vector
//     cur      in  IDX_W   current owner index
//     next_idx out IDX_W   winning index (cur when nothing is requested)
//     found    out 1       at least one request bit was set
module rr_next_picker
  import intersection_pkg::*;
#(
  parameter int N_APPR = 4,
  parameter int IDX_W  = $clog2(N_APPR)
) (
  input  logic [N_APPR-1:0] req,
  input  logic [IDX_W-1:0]  cur,
  output logic [IDX_W-1:0]  next_idx,
  output logic              found
);

  // Walk the distances from farthest to nearest so the nearest hit is the
  // last assignment and therefore the winner.
  always_comb begin
    next_idx = cur;
    found    = 1'b0;
    for (int k = N_APPR; k >= 1; k--) begin
      if (req[(int'(cur) + k) % N_APPR]) begin
        next_idx = IDX_W'((int'(cur) + k) % N_APPR);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Shares one intersection among N_APPR approaches. One approach owns
//   right-of-way; its green runs through yellow and all-red clearance, with
//   min-green, gap-out and max-out timing. The next owner is chosen
//   round-robin among latched/live car requests.
//   Optional build macro: PED_WALK_EN adds a pedestrian WALK phase
//   (ped_req input, walk output, WALK_T parameter).
//   Ports:
//     clk      in  1           clock
//     rst_n    in  1           asynchronous active-low reset
//     has_car  in  N_APPR      per-approach car-present level
//     ped_req  in  1           pedestrian request (PED_WALK_EN only)
//     light    out 3*N_APPR    per approach {green, yellow, red}, one-hot
//     owner    out clog2(N)    approach holding or last holding right-of-way
//     phase    out 2           current phase (phase_t), doubles as FSM state
//     walk     out 1           WALK phase active (PED_WALK_EN only)
//   Handshake: none; has_car and ped_req are levels sampled every posedge,
//   and a request is remembered in pending until its approach is served.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 35,
  parameter int MAX_GREEN = 60,
  parameter int YELLOW_T  = 15,
  parameter int ALL_RED_T = 2,
  parameter int CNT_W     = 7
`ifdef PED_WALK_EN
  , parameter int WALK_T  = 20
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_APPR-1:0]           has_car,
`ifdef PED_WALK_EN
  input  logic                        ped_req,
  output logic                        walk,
`endif
  output logic [3*N_APPR-1:0]         light,
  output logic [$clog2(N_APPR)-1:0]   owner,
  output logic [1:0]                  phase
);

  localparam int OW = $clog2(N_APPR);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALL_RED_T - 1);
`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);
`endif

  phase_t             phase_q;
  logic [OW-1:0]      owner_q;
  logic [CNT_W-1:0]   count_q;
  logic [N_APPR-1:0]  pending_q;
`ifdef PED_WALK_EN
  logic               ped_pend_q;
`endif

  logic [N_APPR-1:0]  owner_mask;
  logic [N_APPR-1:0]  req_vec;
  logic [N_APPR-1:0]  pending_upd;
  logic [N_APPR-1:0]  grant_mask;
  logic               other_req;
  logic               green_done;
  logic [OW-1:0]      pick_idx;
  logic               pick_found;
  logic [OW-1:0]      new_owner;

  // Live cars count alongside latched ones so a request seen this cycle is
  // already eligible at the all-red exit.
  assign req_vec = pending_q | has_car;

  rr_next_picker #(
    .N_APPR (N_APPR),
    .IDX_W  (OW)
  ) u_picker (
    .req      (req_vec),
    .cur      (owner_q),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  assign new_owner = pick_found ? pick_idx : owner_q;

  always_comb begin
    owner_mask = '0;
    grant_mask = '0;
    for (int j = 0; j < N_APPR; j++) begin
      owner_mask[j] = (OW'(j) == owner_q);
      grant_mask[j] = (OW'(j) == new_owner);
    end
  end

  // The green owner's own car never latches: it is being served right now.
  always_comb begin
    pending_upd = pending_q | has_car;
    if (phase_q == PH_GREEN) begin
      pending_upd = pending_q | (has_car & ~owner_mask);
    end
  end

  always_comb begin
    other_req = |(req_vec & ~owner_mask);
`ifdef PED_WALK_EN
    other_req = other_req | ped_pend_q;
`endif
  end

  // Leave green once min-green is served and someone else waits, either
  // because the owner's traffic gapped out or max-green was reached.
  assign green_done = (count_q >= MIN_M1) && other_req &&
                      (!has_car[owner_q] || (count_q == MAX_M1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_GREEN;
      owner_q    <= '0;
      count_q    <= '0;
      pending_q  <= '0;
`ifdef PED_WALK_EN
      ped_pend_q <= 1'b0;
`endif
    end else begin
      pending_q <= pending_upd;
`ifdef PED_WALK_EN
      ped_pend_q <= ped_pend_q | ped_req;
`endif
      case (phase_q)
        PH_GREEN: begin
          if (green_done) begin
            phase_q <= PH_YELLOW;
            count_q <= '0;
          end else if (count_q != MAX_M1) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (count_q == YEL_M1) begin
            phase_q <= PH_ALL_RED;
            count_q <= '0;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        PH_ALL_RED: begin
          if (count_q == AR_M1) begin
            count_q <= '0;
`ifdef PED_WALK_EN
            if (ped_pend_q) begin
              phase_q    <= PH_WALK;
              ped_pend_q <= 1'b0;
            end else begin
              phase_q   <= PH_GREEN;
              owner_q   <= new_owner;
              pending_q <= pending_upd & ~grant_mask;
            end
`else
            phase_q   <= PH_GREEN;
            owner_q   <= new_owner;
            // The granted approach is being served, so its latch clears
            // even if its car is also present this cycle.
            pending_q <= pending_upd & ~grant_mask;
`endif
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
`ifdef PED_WALK_EN
        PH_WALK: begin
          if (count_q == WALK_M1) begin
            phase_q <= PH_ALL_RED;
            count_q <= '0;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
`endif
        default: begin
          // Unreachable encoding: fall back to a safe clearance interval.
          phase_q <= PH_ALL_RED;
          count_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    light = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if ((OW'(i) == owner_q) && (phase_q == PH_GREEN)) begin
        light[3*i +: 3] = LIGHT_GREEN;
      end else if ((OW'(i) == owner_q) && (phase_q == PH_YELLOW)) begin
        light[3*i +: 3] = LIGHT_YELLOW;
      end else begin
        light[3*i +: 3] = LIGHT_RED;
      end
    end
  end

  assign owner = owner_q;
  assign phase = phase_q;
`ifdef PED_WALK_EN
  assign walk  = (phase_q == PH_WALK);
`endif

endmodule
